// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/RV64I instruction decoder with optional
// M-extension, valid/ready handshakes on both sides and a main + skid output
// buffer so a full-rate stream survives back-pressure.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   flush               discard everything buffered plus this cycle's input
//   in_valid/in_ready   upstream handshake (in_ready is a flop output)
//   in_instr, in_pc     instruction word and its address
//   out_valid/out_ready downstream handshake
//   out_*               decoded control bundle held in the main register
//   ill_count           saturating count of illegal instructions delivered
module decode_stage #(
    parameter int XLEN     = 32,
    parameter int ENABLE_M = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_mem_width,
    output logic [4:0]       out_alu_op,
    output logic             out_alu_src1,
    output logic [1:0]       out_alu_src2,
    output logic             out_mem_to_reg,
    output logic             out_mem_write,
    output logic             out_reg_write,
    output logic             out_branch,
    output logic             out_invert_branch,
    output logic             out_jump,
    output logic [1:0]       out_next_pc_sel,
    output logic             out_illegal,
    output logic [CNT_W-1:0] ill_count
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [4:0] ALU_ADD    = 5'b00000;
    localparam logic [4:0] ALU_SUB    = 5'b00001;
    localparam logic [4:0] ALU_AND    = 5'b00100;
    localparam logic [4:0] ALU_OR     = 5'b00101;
    localparam logic [4:0] ALU_XOR    = 5'b00110;
    localparam logic [4:0] ALU_SHL    = 5'b01000;
    localparam logic [4:0] ALU_SHR    = 5'b01010;
    localparam logic [4:0] ALU_SHA    = 5'b01011;
    localparam logic [4:0] ALU_SLT    = 5'b01100;
    localparam logic [4:0] ALU_SLTU   = 5'b01101;
    localparam logic [4:0] ALU_PASS_B = 5'b01111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [2:0]      mem_width;
        logic [4:0]      alu_op;
        logic            alu_src1;
        logic [1:0]      alu_src2;
        logic            mem_to_reg;
        logic            mem_write;
        logic            reg_write;
        logic            branch;
        logic            invert_branch;
        logic            jump;
        logic [1:0]      next_pc_sel;
        logic            illegal;
    } bundle_t;

    // Full combinational decode of one instruction word.
    function automatic bundle_t decode(input logic [31:0] instr, input logic [XLEN-1:0] pc);
        bundle_t    b;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       ill;
        logic       shamt_hi_ok;
        f3  = instr[14:12];
        f7  = instr[31:25];
        ill = 1'b0;
        // On RV32 the shamt is 5 bits, so bit 25 belongs to funct7 and must be 0.
        shamt_hi_ok = (XLEN == 64) || !instr[25];
        b               = '0;
        b.pc            = pc;
        b.rs1           = instr[19:15];
        b.rs2           = instr[24:20];
        b.rd            = instr[11:7];
        b.mem_width     = f3;
        b.alu_op        = ALU_ADD;
        case (instr[6:0])
            OPC_OP: begin
                b.reg_write = 1'b1;
                case (f7)
                    7'h00: begin
                        case (f3)
                            3'b000:  b.alu_op = ALU_ADD;
                            3'b001:  b.alu_op = ALU_SHL;
                            3'b010:  b.alu_op = ALU_SLT;
                            3'b011:  b.alu_op = ALU_SLTU;
                            3'b100:  b.alu_op = ALU_XOR;
                            3'b101:  b.alu_op = ALU_SHR;
                            3'b110:  b.alu_op = ALU_OR;
                            default: b.alu_op = ALU_AND;
                        endcase
                    end
                    7'h20: begin
                        if (f3 == 3'b000) begin
                            b.alu_op = ALU_SUB;
                        end else if (f3 == 3'b101) begin
                            b.alu_op = ALU_SHA;
                        end else begin
                            ill = 1'b1;
                        end
                    end
                    7'h01: begin
                        // MDU codes are 2'b10 followed by funct3.
                        if (ENABLE_M != 0) begin
                            b.alu_op = {2'b10, f3};
                        end else begin
                            ill = 1'b1;
                        end
                    end
                    default: ill = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                b.reg_write = 1'b1;
                b.alu_src2  = 2'b01;
                b.imm       = XLEN'($signed(instr[31:20]));
                case (f3)
                    3'b000: b.alu_op = ALU_ADD;
                    3'b010: b.alu_op = ALU_SLT;
                    3'b011: b.alu_op = ALU_SLTU;
                    3'b100: b.alu_op = ALU_XOR;
                    3'b110: b.alu_op = ALU_OR;
                    3'b111: b.alu_op = ALU_AND;
                    3'b001: begin
                        b.alu_op = ALU_SHL;
                        ill      = (instr[31:26] != 6'b000000) || !shamt_hi_ok;
                    end
                    3'b101: begin
                        b.alu_op = instr[30] ? ALU_SHA : ALU_SHR;
                        ill      = ((instr[31:26] != 6'b000000) && (instr[31:26] != 6'b010000))
                                   || !shamt_hi_ok;
                    end
                    default: ill = 1'b1;
                endcase
                // Shift immediates carry a zero-extended shamt instead of the I-imm.
                if ((f3 == 3'b001) || (f3 == 3'b101)) begin
                    b.imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
                end else begin
                    b.imm = b.imm;
                end
            end
            OPC_LOAD: begin
                b.mem_to_reg = 1'b1;
                b.reg_write  = 1'b1;
                b.alu_src2   = 2'b01;
                b.imm        = XLEN'($signed(instr[31:20]));
                ill = (f3 == 3'b111) || ((XLEN != 64) && ((f3 == 3'b011) || (f3 == 3'b110)));
            end
            OPC_STORE: begin
                b.mem_write = 1'b1;
                b.alu_src2  = 2'b01;
                b.imm       = XLEN'($signed({instr[31:25], instr[11:7]}));
                ill = (XLEN == 64) ? (f3 > 3'b011) : (f3 > 3'b010);
            end
            OPC_BRANCH: begin
                b.branch      = 1'b1;
                b.next_pc_sel = 2'b01;
                b.imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
                // taken = (alu_result != 0) ^ invert_branch
                case (f3)
                    3'b000: begin b.alu_op = ALU_SUB;  b.invert_branch = 1'b1; end
                    3'b001: begin b.alu_op = ALU_SUB;  b.invert_branch = 1'b0; end
                    3'b100: begin b.alu_op = ALU_SLT;  b.invert_branch = 1'b0; end
                    3'b101: begin b.alu_op = ALU_SLT;  b.invert_branch = 1'b1; end
                    3'b110: begin b.alu_op = ALU_SLTU; b.invert_branch = 1'b0; end
                    3'b111: begin b.alu_op = ALU_SLTU; b.invert_branch = 1'b1; end
                    default: ill = 1'b1;
                endcase
            end
            OPC_JAL, OPC_JALR: begin
                // Link value is pc + 4 computed by the ALU.
                b.jump      = 1'b1;
                b.reg_write = 1'b1;
                b.alu_src1  = 1'b1;
                b.alu_src2  = 2'b10;
                if (instr[3]) begin
                    b.next_pc_sel = 2'b01;
                    b.imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
                end else begin
                    b.next_pc_sel = 2'b10;
                    b.imm = XLEN'($signed(instr[31:20]));
                    ill   = (f3 != 3'b000);
                end
            end
            OPC_AUIPC: begin
                b.reg_write = 1'b1;
                b.alu_src1  = 1'b1;
                b.alu_src2  = 2'b01;
                b.imm       = XLEN'($signed({instr[31:12], 12'h000}));
            end
            OPC_LUI: begin
                b.reg_write = 1'b1;
                b.alu_src2  = 2'b01;
                b.alu_op    = ALU_PASS_B;
                b.imm       = XLEN'($signed({instr[31:12], 12'h000}));
            end
            default: ill = 1'b1;
        endcase
        // Illegal words travel down the pipe but must not change any state.
        if (ill) begin
            b.reg_write   = 1'b0;
            b.mem_write   = 1'b0;
            b.mem_to_reg  = 1'b0;
            b.branch      = 1'b0;
            b.jump        = 1'b0;
            b.next_pc_sel = 2'b00;
            b.illegal     = 1'b1;
        end else begin
            b.illegal     = 1'b0;
        end
        return b;
    endfunction

    bundle_t          main_r, skid_r, main_nxt_s, skid_nxt_s, decoded_s;
    logic             out_valid_r, skid_valid_r, in_ready_r;
    logic             out_valid_nxt_s, skid_valid_nxt_s;
    logic             in_fire_s;
    logic [CNT_W-1:0] ill_count_r, ill_count_nxt_s;

    // Next-state of the main/skid buffer pair and the illegal counter.
    always_comb begin
        decoded_s        = decode(in_instr, in_pc);
        in_fire_s        = in_valid && in_ready_r;
        main_nxt_s       = main_r;
        skid_nxt_s       = skid_r;
        out_valid_nxt_s  = out_valid_r;
        skid_valid_nxt_s = skid_valid_r;
        ill_count_nxt_s  = ill_count_r;
        if (flush) begin
            out_valid_nxt_s  = 1'b0;
            skid_valid_nxt_s = 1'b0;
        end else begin
            if (out_valid_r && out_ready && main_r.illegal && (ill_count_r != {CNT_W{1'b1}})) begin
                ill_count_nxt_s = ill_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                ill_count_nxt_s = ill_count_r;
            end
            if (!out_valid_r || out_ready) begin
                // Main register frees up: skid drains first to keep ordering.
                if (skid_valid_r) begin
                    main_nxt_s       = skid_r;
                    out_valid_nxt_s  = 1'b1;
                    skid_valid_nxt_s = 1'b0;
                end else if (in_fire_s) begin
                    main_nxt_s      = decoded_s;
                    out_valid_nxt_s = 1'b1;
                end else begin
                    out_valid_nxt_s = 1'b0;
                end
            end else begin
                // Stalled: an accepted word parks in the skid entry.
                if (in_fire_s) begin
                    skid_nxt_s       = decoded_s;
                    skid_valid_nxt_s = 1'b1;
                end else begin
                    skid_valid_nxt_s = skid_valid_r;
                end
            end
        end
    end

    // State registers; in_ready is registered from the next skid state.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_r       <= '0;
            skid_r       <= '0;
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b0;
            ill_count_r  <= '0;
        end else begin
            main_r       <= main_nxt_s;
            skid_r       <= skid_nxt_s;
            out_valid_r  <= out_valid_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
            in_ready_r   <= !skid_valid_nxt_s;
            ill_count_r  <= ill_count_nxt_s;
        end
    end

    assign in_ready          = in_ready_r;
    assign out_valid         = out_valid_r;
    assign out_pc            = main_r.pc;
    assign out_rs1           = main_r.rs1;
    assign out_rs2           = main_r.rs2;
    assign out_rd            = main_r.rd;
    assign out_imm           = main_r.imm;
    assign out_mem_width     = main_r.mem_width;
    assign out_alu_op        = main_r.alu_op;
    assign out_alu_src1      = main_r.alu_src1;
    assign out_alu_src2      = main_r.alu_src2;
    assign out_mem_to_reg    = main_r.mem_to_reg;
    assign out_mem_write     = main_r.mem_write;
    assign out_reg_write     = main_r.reg_write;
    assign out_branch        = main_r.branch;
    assign out_invert_branch = main_r.invert_branch;
    assign out_jump          = main_r.jump;
    assign out_next_pc_sel   = main_r.next_pc_sel;
    assign out_illegal       = main_r.illegal;
    assign ill_count         = ill_count_r;

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered RV32I/RV64I instruction decode stage with an optional M-extension, sitting between the fetch stage and the register-read/execute stage of the pipelined core. Accepts one instruction per cycle over a valid/ready handshake and emits a decoded control bundle one cycle later. A 2-entry output buffer (main + skid) keeps full throughput under back-pressure. Supports pipeline flush, illegal-instruction tagging and a saturating illegal-instruction counter.

## Interface
- XLEN, 32: datapath width, 32 or 64; sets imm width and shamt width (5 or 6 bits).
- ENABLE_M, 0: 1 decodes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU; 0 tags them illegal.
- CNT_W, 16: illegal-counter width.
- clk  in  1  clock; everything on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  drop all buffered and incoming instructions this cycle.
- in_valid / in_ready  in / out  1 / 1  upstream handshake.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid / out_ready  out / in  1 / 1  downstream handshake.
- out_pc  out  XLEN; out_rs1, out_rs2, out_rd  out  5 each (instr[19:15], [24:20], [11:7]).
- out_imm  out  XLEN  sign-extended immediate (I/S/B/U/J); zero-extended shamt for shift-immediates; 0 otherwise.
- out_mem_width  out  3  funct3.
- out_alu_op  out  5  ALU/MDU operation code.
- out_alu_src1  out  1  0 rs1, 1 pc.
- out_alu_src2  out  2  00 rs2, 01 imm, 10 constant 4.
- out_mem_to_reg, out_mem_write, out_reg_write, out_branch, out_invert_branch, out_jump  out  1 each.
- out_next_pc_sel  out  2  00 pc+4, 01 pc+imm, 10 rs1+imm.
- out_illegal  out  1  instruction is illegal.
- ill_count  out  CNT_W  saturating count of illegal instructions delivered.

## Operation
- alu_op: ADD 00000, SUB 00001, AND 00100, OR 00101, XOR 00110, SHL 01000, SHR 01010, SHA 01011, SLT 01100, SLTU 01101, PASS_B 01111; MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111.
- OP/OP-IMM: reg_write=1, src2 rs2/imm. funct7 0x00 normal; 0x20 only for SUB/SRA/SRAI; 0x01 (OP only) selects M op from funct3. Any other funct7 is illegal.
- Shift-imm: XLEN=32 requires instr[25]=0, else illegal; imm = instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64).
- LOAD: mem_to_reg=1, reg_write=1, ADD, src2 imm; funct3 3'b011/110 legal only for XLEN=64, 3'b111 illegal. STORE: mem_write=1, ADD, src2 imm; funct3 >3'b010 illegal (XLEN=32), >3'b011 illegal (XLEN=64).
- BRANCH: branch=1, src2 rs2, next_pc_sel 01; taken = (alu_result!=0) XOR invert. BEQ SUB/1, BNE SUB/0, BLT SLT/0, BGE SLT/1, BLTU SLTU/0, BGEU SLTU/1; funct3 010/011 illegal.
- JAL: jump=1, reg_write=1, src1 pc, src2 4, ADD, next_pc_sel 01. JALR: same, next_pc_sel 10; funct3≠0 illegal.
- AUIPC: src1 pc, src2 imm, ADD. LUI: src2 imm, PASS_B.
- Any other opcode, including all-zero instruction: illegal.
- Illegal instructions forward with out_illegal=1 and reg_write, mem_write, mem_to_reg, branch, jump forced 0; next_pc_sel 00.
- ill_count increments on out_valid & out_ready & out_illegal; holds at 2^CNT_W-1.

## Timing
- Reset: out_valid=0, skid empty, in_ready=0 while rst high, ill_count=0, all bundle outputs 0.
- Latency 1 cycle: accepted on cycle N, visible on out_* in cycle N+1.
- in_ready = !skid_valid (registered, no combinational path from out_ready).
- Input accepted while out_valid & !out_ready goes to skid; on next out handshake skid moves to main register.
- Throughput 1/cycle with out_ready held 1; out_* stable while out_valid & !out_ready.
- flush: next cycle out_valid=0, skid empty; in_valid in the flush cycle is dropped; ill_count not affected by flushed entries.
- flush and rst have priority over every handshake in the same cycle.

## Test plan
- Stream ADDI x1,x0,5 (0x00500093) with out_ready=1 -> next cycle out_valid=1, alu_op 00000, src2 01, imm 5, reg_write=1.
- BGE x1,x2,-8 (0xFE20DCE3) -> branch=1, alu_op 01100, invert=1, imm 0xFFFFFFF8, next_pc_sel 01.
- ENABLE_M=0 then 1, MUL x3,x1,x2 (0x022081B3) -> illegal=1, reg_write=0, ill_count 1 / illegal=0, alu_op 10000.
- out_ready=0 for 3 cycles while 3 instructions offered -> 2 held (main+skid), in_ready=0, third held upstream; release -> all 3 in order, none lost.
- flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing emitted.
- XLEN=32, SLLI with instr[25]=1 (0x02009093) -> illegal=1; 2^CNT_W+3 illegal words -> ill_count saturates at all-ones.
